data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 21 ++
 rtl/dmem_dualport_ram.sv | 51 +++++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module : data_mem_responder_pkg
// Brief  : Shared types and widths for the data memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  localparam int PROC_ADDR_W = 24;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dmr_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_dualport_ram.sv
// ============================================================================
// Module : dmem_dualport_ram
// Brief  : Byte memory with processor and host ports, synchronous read-first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_dualport_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              p_rd_zero,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              h_we,
  input  logic              h_re,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_p_rdata;
  logic [DATA_W-1:0] r_h_rdata;

  // Storage is never reset; the two write ports are never active together.
  always_ff @(posedge clk) begin
    if (p_we) r_mem[p_addr] <= p_wdata;
    if (h_we) r_mem[h_addr] <= h_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_rdata <= '0;
      r_h_rdata <= '0;
    end else begin
      r_p_rdata <= p_rd_zero ? '0 : r_mem[p_addr];
      if (h_re) r_h_rdata <= r_mem[h_addr];
    end
  end

  assign p_rdata = r_p_rdata;
  assign h_rdata = r_h_rdata;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : LOAD/RUN/DONE sequencer around a dual-port data memory.
//          Optional macro DMEM_OOB_CHECK_EN enables processor range checking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PROC_ADDR_W-1:0] DRAM_addr,
  input  logic [DATA_W-1:0]      DRAM_data_write,
  input  logic                   write,
  output logic [DATA_W-1:0]      data_in,
  input  logic                   finish,
  output logic                   enable,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_wr,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic [DATA_W-1:0]      host_rdata,
  output logic                   host_rvalid,
  input  logic                   host_start,
  input  logic                   host_rearm,
  output logic [31:0]            run_cycles,
  output logic                   oob_err
);

  dmr_state_t  r_state;
  dmr_state_t  w_state_nxt;
  logic [31:0] r_run_cycles;
  logic        r_host_rvalid;
  logic        w_oob;
  logic        w_host_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    enable      = 1'b0;
    host_ready  = 1'b0;
    case (r_state)
      LOAD: begin
        host_ready = 1'b1;
        if (host_start) w_state_nxt = RUN;
      end
      RUN: begin
        enable = 1'b1;
        if (finish) w_state_nxt = DONE;
      end
      DONE: begin
        host_ready = 1'b1;
        if (host_rearm) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

`ifdef DMEM_OOB_CHECK_EN
  logic r_oob_err;

  assign w_oob = (r_state == RUN) && (|DRAM_addr[PROC_ADDR_W-1:ADDR_W]);

  always_ff @(posedge clk) begin
    if (!rst_n)     r_oob_err <= 1'b0;
    else if (w_oob) r_oob_err <= 1'b1;
  end

  assign oob_err = r_oob_err;
`else
  logic [PROC_ADDR_W-ADDR_W-1:0] w_unused_addr_hi;

  // Upper address bits are dropped: the processor address wraps.
  assign w_unused_addr_hi = DRAM_addr[PROC_ADDR_W-1:ADDR_W];
  assign w_oob            = 1'b0;
  assign oob_err          = 1'b0;
`endif

  assign w_host_acc = rst_n && host_valid && host_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_cycles  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= w_host_acc && !host_wr;
      if (r_state == LOAD && w_state_nxt == RUN)
        r_run_cycles <= '0;
      else if (r_state == RUN && r_run_cycles != 32'hFFFF_FFFF)
        r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign run_cycles  = r_run_cycles;
  assign host_rvalid = r_host_rvalid;

  dmem_dualport_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_we      (rst_n && (r_state == RUN) && write && !w_oob),
    .p_addr    (DRAM_addr[ADDR_W-1:0]),
    .p_wdata   (DRAM_data_write),
    .p_rd_zero (w_oob),
    .p_rdata   (data_in),
    .h_we      (w_host_acc && host_wr),
    .h_re      (w_host_acc && !host_wr),
    .h_addr    (host_addr),
    .h_wdata   (host_wdata),
    .h_rdata   (host_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Self-checking bench: vector table, random traffic vs model, corners.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

`ifdef DMEM_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  localparam int S_LOAD = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic        clk;
  logic        rst_n;
  logic [23:0] DRAM_addr;
  logic [7:0]  DRAM_data_write;
  logic        write;
  logic [7:0]  data_in;
  logic        finish;
  logic        enable;
  logic        host_valid;
  logic        host_ready;
  logic        host_wr;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        host_start;
  logic        host_rearm;
  logic [31:0] run_cycles;
  logic        oob_err;

  data_mem_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .DRAM_addr       (DRAM_addr),
    .DRAM_data_write (DRAM_data_write),
    .write           (write),
    .data_in         (data_in),
    .finish          (finish),
    .enable          (enable),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_wr         (host_wr),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_rdata      (host_rdata),
    .host_rvalid     (host_rvalid),
    .host_start      (host_start),
    .host_rearm      (host_rearm),
    .run_cycles      (run_cycles),
    .oob_err         (oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_on = 1'b1;

  // Reference model state
  logic [7:0]  m_mem [4096];
  int          m_state;
  logic [7:0]  m_di;
  logic [7:0]  m_hrd;
  logic        m_rv;
  logic        m_oob;
  logic [31:0] m_rc;

  typedef struct packed {
    logic        hv;
    logic        hwr;
    logic [11:0] ha;
    logic [7:0]  hwd;
    logic        st;
    logic        ra;
    logic        wr;
    logic [23:0] da;
    logic [7:0]  dwd;
    logic        fin;
    logic        e_en;
    logic        e_rdy;
    logic        e_rv;
    logic [7:0]  e_hrd;
    logic [7:0]  e_di;
    logic [31:0] e_rc;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    DRAM_addr = 24'h0; DRAM_data_write = 8'h0; write = 1'b0; finish = 1'b0;
    host_valid = 1'b0; host_wr = 1'b0; host_addr = 12'h0; host_wdata = 8'h0;
    host_start = 1'b0; host_rearm = 1'b0;
  endtask

  // Behavioural rules applied at a rising edge, from the inputs seen there.
  task automatic model_edge();
    bit         acc;
    bit         oob;
    logic [7:0] old_p;
    if (!rst_n) begin
      m_state = S_LOAD; m_di = 8'h0; m_hrd = 8'h0; m_rv = 1'b0;
      m_oob = 1'b0; m_rc = 32'h0;
    end else begin
      acc   = host_valid && (m_state != S_RUN);
      oob   = OOB_EN && (m_state == S_RUN) && (DRAM_addr[23:12] != 12'h0);
      old_p = m_mem[DRAM_addr[11:0]];
      m_rv  = acc && !host_wr;
      if (m_rv) m_hrd = m_mem[host_addr];
      m_di = oob ? 8'h0 : old_p;
      if (m_state == S_RUN && write && !oob) m_mem[DRAM_addr[11:0]] = DRAM_data_write;
      if (acc && host_wr) m_mem[host_addr] = host_wdata;
      if (oob) m_oob = 1'b1;
      if (m_state == S_LOAD && host_start) m_rc = 32'h0;
      else if (m_state == S_RUN && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 32'd1;
      case (m_state)
        S_LOAD:  if (host_start) m_state = S_RUN;
        S_RUN:   if (finish)     m_state = S_DONE;
        default: if (host_rearm) m_state = S_LOAD;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (check_on) begin
      chk("enable",      32'(enable),      32'(m_state == S_RUN));
      chk("host_ready",  32'(host_ready),  32'(m_state != S_RUN));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_rv));
      chk("host_rdata",  32'(host_rdata),  32'(m_hrd));
      chk("data_in",     32'(data_in),     32'(m_di));
      chk("run_cycles",  run_cycles,       m_rc);
      chk("oob_err",     32'(oob_err),     32'(m_oob));
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic host_op(input logic wr, input logic [11:0] a, input logic [7:0] d);
    idle_inputs();
    host_valid = 1'b1; host_wr = wr; host_addr = a; host_wdata = d;
    step();
    idle_inputs();
  endtask

  initial begin
    logic [7:0] saved;
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h0;
    m_state = S_LOAD; m_di = 8'h0; m_hrd = 8'h0; m_rv = 1'b0; m_oob = 1'b0; m_rc = 32'h0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_enable",     32'(enable),     32'h0);
    chk("rst_host_ready", 32'(host_ready), 32'h1);
    chk("rst_run_cycles", run_cycles,      32'h0);
    chk("rst_data_in",    32'(data_in),    32'h0);
    rst_n = 1'b1;

    // Fill memory with a known pattern: mem[a] = a[7:0] ^ 0x5A
    check_on = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      logic [11:0] aa;
      aa = 12'(a);
      host_op(1'b1, aa, aa[7:0] ^ 8'h5A);
    end
    check_on = 1'b1;

    //           hv   hwr  ha       hwd    st   ra   wr   da          dwd    fin   en   rdy  rv   hrd    di     rc
    tbl[0]  = '{1'b1,1'b1,12'h010,8'hA5,1'b0,1'b0,1'b0,24'h000010,8'h00,1'b0, 1'b0,1'b1,1'b0,8'h00,8'h4A,32'd0};
    tbl[1]  = '{1'b1,1'b0,12'h010,8'h00,1'b0,1'b0,1'b0,24'h000010,8'h00,1'b0, 1'b0,1'b1,1'b1,8'hA5,8'hA5,32'd0};
    tbl[2]  = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b0,24'h000010,8'h00,1'b0, 1'b0,1'b1,1'b0,8'hA5,8'hA5,32'd0};
    tbl[3]  = '{1'b1,1'b1,12'h030,8'h11,1'b1,1'b0,1'b0,24'h000030,8'h00,1'b0, 1'b1,1'b0,1'b0,8'hA5,8'h6A,32'd0};
    tbl[4]  = '{1'b1,1'b1,12'h040,8'hEE,1'b0,1'b0,1'b1,24'h000020,8'h3C,1'b0, 1'b1,1'b0,1'b0,8'hA5,8'h7A,32'd1};
    tbl[5]  = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b0,24'h000020,8'h00,1'b0, 1'b1,1'b0,1'b0,8'hA5,8'h3C,32'd2};
    tbl[6]  = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b0,24'h000030,8'h00,1'b0, 1'b1,1'b0,1'b0,8'hA5,8'h11,32'd3};
    tbl[7]  = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b0,24'h000040,8'h00,1'b0, 1'b1,1'b0,1'b0,8'hA5,8'h1A,32'd4};
    tbl[8]  = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b1,24'h000050,8'h77,1'b1, 1'b0,1'b1,1'b0,8'hA5,8'h0A,32'd5};
    tbl[9]  = '{1'b0,1'b0,12'h000,8'h00,1'b1,1'b0,1'b0,24'h000050,8'h00,1'b0, 1'b0,1'b1,1'b0,8'hA5,8'h77,32'd5};
    tbl[10] = '{1'b1,1'b0,12'h040,8'h00,1'b0,1'b0,1'b0,24'h000050,8'h00,1'b0, 1'b0,1'b1,1'b1,8'h1A,8'h77,32'd5};
    tbl[11] = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b1,1'b0,24'h000050,8'h00,1'b0, 1'b0,1'b1,1'b0,8'h1A,8'h77,32'd5};
    tbl[12] = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b1,24'h000060,8'h99,1'b0, 1'b0,1'b1,1'b0,8'h1A,8'h3A,32'd5};
    tbl[13] = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b0,24'h000060,8'h00,1'b0, 1'b0,1'b1,1'b0,8'h1A,8'h3A,32'd5};
    tbl[14] = '{1'b0,1'b0,12'h000,8'h00,1'b1,1'b0,1'b0,24'h000060,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h1A,8'h3A,32'd0};
    tbl[15] = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,1'b0,24'h000060,8'h00,1'b1, 1'b0,1'b1,1'b0,8'h1A,8'h3A,32'd1};
    tbl[16] = '{1'b0,1'b0,12'h000,8'h00,1'b0,1'b1,1'b0,24'h000060,8'h00,1'b0, 1'b0,1'b1,1'b0,8'h1A,8'h3A,32'd1};

    for (int i = 0; i < 17; i++) begin
      host_valid = tbl[i].hv;  host_wr = tbl[i].hwr; host_addr = tbl[i].ha;
      host_wdata = tbl[i].hwd; host_start = tbl[i].st; host_rearm = tbl[i].ra;
      write = tbl[i].wr; DRAM_addr = tbl[i].da; DRAM_data_write = tbl[i].dwd;
      finish = tbl[i].fin;
      step();
      chk($sformatf("tbl%0d_enable", i),      32'(enable),      32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_host_ready", i),  32'(host_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_host_rvalid", i), 32'(host_rvalid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_host_rdata", i),  32'(host_rdata),  32'(tbl[i].e_hrd));
      chk($sformatf("tbl%0d_data_in", i),     32'(data_in),     32'(tbl[i].e_di));
      chk($sformatf("tbl%0d_run_cycles", i),  run_cycles,       tbl[i].e_rc);
    end
    idle_inputs();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      host_valid = 1'($urandom_range(0, 1));
      host_wr    = 1'($urandom_range(0, 1));
      host_addr  = 12'($urandom_range(0, 63));
      host_wdata = 8'($urandom);
      host_start = ($urandom_range(0, 7) == 0);
      host_rearm = ($urandom_range(0, 7) == 0);
      write      = 1'($urandom_range(0, 1));
      DRAM_addr  = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 63));
      DRAM_data_write = 8'($urandom);
      finish     = ($urandom_range(0, 19) == 0);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();

    // 100-cycle run with host hammering; memory must be untouched
    do_reset();
    saved = m_mem[12'h010];
    host_start = 1'b1;
    step();
    idle_inputs();
    for (int i = 1; i <= 100; i++) begin
      host_valid = 1'b1; host_wr = 1'b1; host_addr = 12'h010; host_wdata = ~saved;
      finish = (i == 100);
      step();
      if (i == 50) chk("run_host_ready", 32'(host_ready), 32'h0);
    end
    idle_inputs();
    chk("run100_enable",     32'(enable),     32'h0);
    chk("run100_run_cycles", run_cycles,      32'd100);
    step();
    chk("run100_hold",       run_cycles,      32'd100);
    host_op(1'b0, 12'h010, 8'h00);
    chk("run100_mem_intact", 32'(host_rdata), 32'(saved));

    // Processor write to an address beyond the memory
    do_reset();
    host_op(1'b1, 12'h010, 8'h3C);
    host_start = 1'b1;
    step();
    idle_inputs();
    write = 1'b1; DRAM_addr = 24'h001010; DRAM_data_write = 8'hC3;
    step();
    idle_inputs();
    finish = 1'b1;
    step();
    idle_inputs();
    host_op(1'b0, 12'h010, 8'h00);
    chk("oob_mem010", 32'(host_rdata), OOB_EN ? 32'h3C : 32'hC3);
    chk("oob_flag",   32'(oob_err),    32'(OOB_EN));

    // Reset in the middle of a run: no write in the reset cycle
    do_reset();
    chk("oob_cleared", 32'(oob_err), 32'h0);
    host_start = 1'b1;
    step();
    idle_inputs();
    write = 1'b1; DRAM_addr = 24'h000070; DRAM_data_write = 8'h5E;
    step();
    step();
    write = 1'b1; DRAM_addr = 24'h000070; DRAM_data_write = 8'hFF;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    chk("midrst_enable",     32'(enable),     32'h0);
    chk("midrst_host_ready", 32'(host_ready), 32'h1);
    chk("midrst_run_cycles", run_cycles,      32'h0);
    host_op(1'b0, 12'h070, 8'h00);
    chk("midrst_mem070",     32'(host_rdata), 32'h5E);
    host_op(1'b0, 12'h010, 8'h00);
    chk("midrst_mem010",     32'(host_rdata), OOB_EN ? 32'h3C : 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
